// File: rtl/fpu_issue_ctrl_if.sv
// Bundles the pipeline request/response, FPU and CSR signals of the FP issue controller.
// master: pipeline side, slave: the controller itself, fp: FPU datapath side.
interface fpu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [4:0]  req_rd;
    logic [2:0]  req_rm;
    logic [7:0]  req_funct7;
    logic        req_lw;
    logic        req_sw;
    logic [31:0] req_dload;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        illegal_rm;

    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [4:0]  f_rd;
    logic [2:0]  f_frm_in;
    logic [7:0]  f_funct_7;
    logic        f_LW;
    logic        f_SW;
    logic [31:0] dload_ext;
    logic [31:0] FPU_all_out;
    logic [4:0]  f_flags;
    logic        f_ready;

    logic        csr_wen;
    logic [1:0]  csr_sel;
    logic [7:0]  csr_wdata;
    logic [7:0]  csr_rdata;

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_rm, req_funct7,
               req_lw, req_sw, req_dload, resp_ready, csr_wen, csr_sel, csr_wdata,
        input  req_ready, resp_valid, resp_data, resp_timeout, illegal_rm, csr_rdata
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_rm, req_funct7,
               req_lw, req_sw, req_dload, resp_ready, csr_wen, csr_sel, csr_wdata,
               FPU_all_out, f_flags, f_ready,
        output req_ready, resp_valid, resp_data, resp_timeout, illegal_rm, csr_rdata,
               f_rs1, f_rs2, f_rd, f_frm_in, f_funct_7, f_LW, f_SW, dload_ext
    );

    modport fp (
        input  f_rs1, f_rs2, f_rd, f_frm_in, f_funct_7, f_LW, f_SW, dload_ext,
        output FPU_all_out, f_flags, f_ready
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP op at a time to the FPU, resolves dynamic rounding, times out a stuck FPU
// and owns the frm / sticky fflags CSR state.
//
// state | meaning
// IDLE  | ready for a new op; illegal-rm ops are rejected here
// ISSUE | one cycle, f_LW/f_SW strobed; load/store result captured
// WAIT  | arithmetic op in flight, timeout counter running
// DONE  | response presented until resp_ready
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic           clk,
    input logic           n_rst,
    fpu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t state, state_nxt;

    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [7:0]       funct7_q;
    logic             lw_q, sw_q;
    logic [31:0]      dload_q;
    logic [2:0]       rm_q;
    logic [2:0]       frm_q, frm_nxt;
    logic [4:0]       fflags_q, fflags_nxt, fflags_base;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      resp_data_q;
    logic             resp_timeout_q;
    logic             illegal_rm_q;

    logic [2:0] eff_rm;
    logic       ldst_req, rm_bad, fire, accept, reject, wait_done;

    // rm=7 defers to frm; reserved values 5..7 after resolution are illegal for arithmetic ops.
    assign eff_rm    = (bus.req_rm == 3'b111) ? frm_q : bus.req_rm;
    assign ldst_req  = bus.req_lw | bus.req_sw;
    assign rm_bad    = (eff_rm == 3'd5) || (eff_rm == 3'd6) || (eff_rm == 3'd7);
    assign fire      = bus.req_valid && (state == IDLE);
    assign accept    = fire && (ldst_req || !rm_bad);
    assign reject    = fire && !ldst_req && rm_bad;
    assign wait_done = (state == WAIT) && bus.f_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.f_LW       = 1'b0;
        bus.f_SW       = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.f_LW  = lw_q;
                bus.f_SW  = sw_q;
                state_nxt = (lw_q || sw_q) ? DONE : WAIT;
            end
            WAIT: begin
                if (bus.f_ready || (cnt_q == CNT_LAST)) state_nxt = DONE;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A CSR write and a flag accumulation in the same cycle merge: written value | f_flags.
    always_comb begin
        frm_nxt     = frm_q;
        fflags_base = fflags_q;
        if (bus.csr_wen) begin
            case (bus.csr_sel)
                2'd0: fflags_base = bus.csr_wdata[4:0];
                2'd1: frm_nxt     = bus.csr_wdata[2:0];
                2'd2: begin
                    frm_nxt     = bus.csr_wdata[7:5];
                    fflags_base = bus.csr_wdata[4:0];
                end
                default: ;
            endcase
        end
        fflags_nxt = fflags_base | (wait_done ? bus.f_flags : 5'd0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            funct7_q       <= '0;
            lw_q           <= 1'b0;
            sw_q           <= 1'b0;
            dload_q        <= '0;
            rm_q           <= '0;
            frm_q          <= '0;
            fflags_q       <= '0;
            cnt_q          <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
            illegal_rm_q   <= 1'b0;
        end else begin
            frm_q        <= frm_nxt;
            fflags_q     <= fflags_nxt;
            illegal_rm_q <= reject;
            if (accept) begin
                rs1_q    <= bus.req_rs1;
                rs2_q    <= bus.req_rs2;
                rd_q     <= bus.req_rd;
                funct7_q <= bus.req_funct7;
                lw_q     <= bus.req_lw;
                sw_q     <= bus.req_sw;
                dload_q  <= bus.req_dload;
                rm_q     <= eff_rm;
            end
            case (state)
                ISSUE: begin
                    if (lw_q || sw_q) resp_data_q <= bus.FPU_all_out;
                    else              cnt_q       <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.f_ready) begin
                        resp_data_q <= bus.FPU_all_out;
                    end else if (cnt_q == CNT_LAST) begin
                        resp_timeout_q <= 1'b1;
                        resp_data_q    <= '0;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) resp_timeout_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_data    = resp_data_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.illegal_rm   = illegal_rm_q;
    assign bus.csr_rdata    = {frm_q, fflags_q};
    assign bus.f_rs1        = rs1_q;
    assign bus.f_rs2        = rs2_q;
    assign bus.f_rd         = rd_q;
    assign bus.f_funct_7    = funct7_q;
    assign bus.f_frm_in     = rm_q;
    assign bus.dload_ext    = dload_q;
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequencing controller between the execute stage and the FPU datapath (FPU_all, reached through the fp modport). It accepts one FP operation at a time over a valid/ready handshake and resolves dynamic rounding mode. It drives the FPU operand, operation and destination fields, waits for f_ready under a timeout, and returns a response to the pipeline. It also owns the architectural frm and sticky fflags CSR state.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before forced completion with error; must be >= 2
CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  asynchronous active-low reset
req_valid  input  1  pipeline presents an FP op
req_ready  output  1  controller can accept an op
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_rd  input  5  destination register
req_rm  input  3  instruction rm field
req_funct7  input  8  operation select
req_lw  input  1  FP load
req_sw  input  1  FP store
req_dload  input  32  load data for FP load
resp_valid  output  1  result ready for pipeline
resp_ready  input  1  pipeline takes response
resp_data  output  32  FPU_all_out captured at completion
resp_timeout  output  1  qualifies resp_valid: op timed out
illegal_rm  output  1  one-cycle pulse: rejected op with reserved rm
f_rs1, f_rs2, f_rd  output  5 each  to FPU
f_frm_in  output  3  resolved rounding mode to FPU
f_funct_7  output  8  to FPU
f_LW, f_SW  output  1 each  to FPU, asserted in ISSUE only
dload_ext  output  32  to FPU
FPU_all_out  input  32  FPU result
f_flags  input  5  FPU exception flags {NV,DZ,OF,UF,NX}
f_ready  input  1  FPU completion
csr_wen  input  1  CSR write strobe
csr_sel  input  2  0=fflags, 1=frm, 2=fcsr, 3=ignored
csr_wdata  input  8  write data (fcsr: [7:5]=frm, [4:0]=fflags)
csr_rdata  output  8  {frm, fflags}, combinational from registers

Behaviour:
- Clock is clk; reset is n_rst, asynchronous, active-low. Reset forces: state=IDLE, all latched fields 0, frm=0, fflags=0, counter=0, resp_valid=0, resp_timeout=0, illegal_rm=0, resp_data=0.
- Reset mid-operation aborts the op silently; no response is produced.
- req_ready = (state==IDLE). Handshake fires when req_valid && req_ready.
- Rounding resolution: eff_rm = (req_rm==3'b111) ? frm : req_rm.
  - If eff_rm is 5 or 6, the op is rejected: illegal_rm pulses for one cycle, state stays IDLE, nothing is latched.
  - If frm holds 5, 6 or 7 and req_rm==7, the op is likewise rejected.
- Loads and stores ignore the rm check.
- States: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on accepted legal op, latch rs1/rs2/rd/funct7/lw/sw/dload/eff_rm, then go to ISSUE.
  - ISSUE (exactly 1 cycle): f_LW/f_SW driven from the latch. If lw or sw, capture FPU_all_out into resp_data and go to DONE. Otherwise clear the counter and go to WAIT.
  - WAIT: counter increments each cycle.
    - f_ready=1: capture FPU_all_out into resp_data, OR f_flags into fflags, go to DONE.
    - Counter reaching TIMEOUT_CYCLES-1 with f_ready=0: set resp_timeout, resp_data=0, fflags unchanged, go to DONE.
    - f_ready and timeout on the same cycle: f_ready wins.
  - DONE: resp_valid=1, resp_data and resp_timeout held stable. When resp_ready=1, clear resp_valid and resp_timeout and go to IDLE.
- Minimum latency: accept at cycle 0, ISSUE at 1, resp_valid at 2 for load/store. An arithmetic op with f_ready seen in WAIT cycle k gives resp_valid at 3+k.
- f_rs1/f_rs2/f_rd/f_funct_7/f_frm_in/dload_ext are held from the latch in every state, so they stay stable throughout an op. f_LW and f_SW are 0 outside ISSUE.
- f_ready in IDLE, ISSUE or DONE is ignored.
- CSR writes are legal in any state.
  - sel=0 writes fflags, sel=1 writes frm (3 bits), sel=2 writes both, sel=3 is a no-op.
  - A CSR write and a flag accumulation in the same cycle yield next fflags = written_value | f_flags.
  - An frm write does not affect an op already latched.

Test Plan:
- Reset, then idle: csr_rdata=0x00, req_ready=1, resp_valid=0. Assert n_rst low mid-WAIT: state IDLE immediately, no resp_valid after release.
- Arithmetic op with rm=0, funct7=0x00. f_ready asserted 3 cycles into WAIT with FPU_all_out=0x3F800000 and f_flags=5'b00001. Required: resp_data=0x3F800000, fflags=0x01, resp_valid held until resp_ready.
- csr write sel=1 data=3'b010, then op with rm=7: f_frm_in=3'b010. Op with rm=5: illegal_rm pulse, req_ready stays 1. csr frm=6 then rm=7: rejected.
- Load with dload=0xDEADBEEF: f_LW=1 for exactly one cycle, f_frm_in irrelevant, resp_valid at cycle 2, no wait on f_ready.
- f_ready never asserted, TIMEOUT_CYCLES=64: resp_valid with resp_timeout=1, resp_data=0, fflags unchanged.
- fflags=0x01 and f_ready with f_flags=0x10, same cycle as csr write sel=0 data=0x04: fflags=0x14. Second op with f_flags=0x02 gives 0x16 (sticky).
